// File: rtl/prog_loader_if.sv
// Bus bundle for prog_loader: UART byte receive, UART byte transmit and
// instruction-memory write port. master = loader side, slave = environment.
interface prog_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_ferr;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        input  rx_data, rx_ready, rx_ferr, tx_busy,
        output tx_start, tx_data, im_we, im_addr, im_wdata
    );

    modport slave (
        output rx_data, rx_ready, rx_ferr, tx_busy,
        input  tx_start, tx_data, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a big-endian word count followed by that many
// big-endian 32-bit words over a UART byte stream, writes them into the
// instruction memory, then answers 0xAA (success) or 0x55 (failure).
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start, incoming bytes ignored
// HDR     | assembling the 4-byte word count
// DATA    | assembling words, one memory write per 4 bytes
// CKSUM   | waiting for the XOR checksum byte (checksum builds only)
// ACK     | waiting for transmitter idle to send 0xAA
// WAIT_TX | letting the 0xAA byte drain
// DONE    | load succeeded, terminal until reset
// ERR     | send 0x55, drain it, then flag err; terminal until reset
module prog_loader #(
    parameter int ADDR_W = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    prog_loader_if.master bus,
    output logic          done,
    output logic          err,
    output logic [31:0]   word_cnt
);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, CKSUM, ACK, WAIT_TX, DONE, ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CKSUM;
`else
    localparam state_t LOAD_END = ACK;
`endif

    // Largest accepted word count is the full memory depth.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    // ERR sub-phases: send the 0x55 byte, let it drain, then hold err.
    localparam logic [1:0] EPH_SEND  = 2'd0;
    localparam logic [1:0] EPH_DRAIN = 2'd1;
    localparam logic [1:0] EPH_HOLD  = 2'd2;

    state_t            state, state_nx;
    logic [1:0]        err_ph, err_ph_nx;
    logic [1:0]        byte_idx, byte_idx_nx;
    logic [23:0]       shift, shift_nx;
    logic [31:0]       n_words, n_words_nx;
    logic [31:0]       word_cnt_r, word_cnt_nx;
    logic              im_we_r, im_we_nx;
    logic [ADDR_W-1:0] im_addr_r, im_addr_nx;
    logic [31:0]       im_wdata_r, im_wdata_nx;
    logic              tx_start_r, tx_start_nx;
    logic [7:0]        tx_data_r, tx_data_nx;
    logic [31:0]       assembled;
    logic [31:0]       word_cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum, csum_nx;
`endif

    assign assembled    = {shift, bus.rx_data};
    assign word_cnt_inc = word_cnt_r + 32'd1;

    // Next-state and next-output decode for the whole loader.
    always_comb begin
        state_nx    = state;
        err_ph_nx   = err_ph;
        byte_idx_nx = byte_idx;
        shift_nx    = shift;
        n_words_nx  = n_words;
        word_cnt_nx = word_cnt_r;
        im_we_nx    = 1'b0;
        im_addr_nx  = im_addr_r;
        im_wdata_nx = im_wdata_r;
        tx_start_nx = 1'b0;
        tx_data_nx  = tx_data_r;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_nx     = csum;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = HDR;
                    byte_idx_nx = 2'd0;
                end
            end
            HDR: begin
                if (bus.rx_ready) begin
                    if (bus.rx_ferr) begin
                        state_nx  = ERR;
                        err_ph_nx = EPH_SEND;
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                        shift_nx    = {shift[15:0], bus.rx_data};
                        if (byte_idx == 2'd3) begin
                            n_words_nx = assembled;
                            if (assembled == 32'd0) begin
                                state_nx = LOAD_END;
                            end else if ({1'b0, assembled} > DEPTH) begin
                                state_nx  = ERR;
                                err_ph_nx = EPH_SEND;
                            end else begin
                                state_nx = DATA;
                            end
                        end
                    end
                end
            end
            DATA: begin
                if (bus.rx_ready) begin
                    if (bus.rx_ferr) begin
                        state_nx  = ERR;
                        err_ph_nx = EPH_SEND;
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                        shift_nx    = {shift[15:0], bus.rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_nx     = csum ^ bus.rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            im_we_nx    = 1'b1;
                            im_addr_nx  = word_cnt_r[ADDR_W-1:0];
                            im_wdata_nx = assembled;
                            word_cnt_nx = word_cnt_inc;
                            if (word_cnt_inc == n_words) begin
                                state_nx = LOAD_END;
                            end
                        end
                    end
                end
            end
            CKSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (bus.rx_ready) begin
                    if (bus.rx_ferr || (bus.rx_data != csum)) begin
                        state_nx  = ERR;
                        err_ph_nx = EPH_SEND;
                    end else begin
                        state_nx = ACK;
                    end
                end
`else
                state_nx  = ERR;
                err_ph_nx = EPH_SEND;
`endif
            end
            ACK: begin
                if (!bus.tx_busy) begin
                    tx_start_nx = 1'b1;
                    tx_data_nx  = 8'hAA;
                    state_nx    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // tx_start is high only in the first WAIT_TX cycle, which
                // gives the transmitter one cycle to raise tx_busy.
                if (!tx_start_r && !bus.tx_busy) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
            end
            ERR: begin
                case (err_ph)
                    EPH_SEND: begin
                        if (!bus.tx_busy) begin
                            tx_start_nx = 1'b1;
                            tx_data_nx  = 8'h55;
                            err_ph_nx   = EPH_DRAIN;
                        end
                    end
                    EPH_DRAIN: begin
                        if (!tx_start_r && !bus.tx_busy) begin
                            err_ph_nx = EPH_HOLD;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            err_ph     <= EPH_SEND;
            byte_idx   <= 2'd0;
            shift      <= '0;
            n_words    <= '0;
            word_cnt_r <= '0;
            im_we_r    <= 1'b0;
            im_addr_r  <= '0;
            im_wdata_r <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            state      <= state_nx;
            err_ph     <= err_ph_nx;
            byte_idx   <= byte_idx_nx;
            shift      <= shift_nx;
            n_words    <= n_words_nx;
            word_cnt_r <= word_cnt_nx;
            im_we_r    <= im_we_nx;
            im_addr_r  <= im_addr_nx;
            im_wdata_r <= im_wdata_nx;
            tx_start_r <= tx_start_nx;
            tx_data_r  <= tx_data_nx;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= csum_nx;
`endif
        end
    end

    assign bus.im_we    = im_we_r;
    assign bus.im_addr  = im_addr_r;
    assign bus.im_wdata = im_wdata_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign word_cnt     = word_cnt_r;
    assign done         = (state == DONE);
    assign err          = (state == ERR) && (err_ph == EPH_HOLD);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have ports: clk input 1 clock; rstn input 1 reset, synchronous, active-low.
REQ-003 SHALL have ports: start input 1 begin load (level, sampled in IDLE); rx_data input 8 received byte; rx_ready input 1 one-cycle byte-valid strobe; rx_ferr input 1 framing error qualifying rx_ready.
REQ-004 SHALL have ports: tx_start output 1 one-cycle send strobe; tx_data output 8 byte to send; tx_busy input 1 transmitter busy.
REQ-005 SHALL have ports: im_we output 1 instruction-memory write enable; im_addr output ADDR_W word address; im_wdata output 32 instruction word.
REQ-006 SHALL have ports: done output 1 load complete (sticky); err output 1 load failed (sticky); word_cnt output 32 words written so far.

Function
REQ-007 SHALL implement states IDLE, HDR, DATA, CKSUM, ACK, WAIT_TX, DONE, ERR.
REQ-008 In IDLE, start=1 SHALL transition to HDR next cycle; bytes arriving in IDLE SHALL be ignored.
REQ-009 HDR SHALL assemble four bytes, big-endian, into word count N; after the 4th byte, N=0 SHALL go to ACK (or CKSUM if enabled), N>2^ADDR_W SHALL go to ERR, otherwise to DATA.
REQ-010 DATA SHALL assemble four bytes big-endian per word; on the 4th byte's rx_ready cycle +1, im_we SHALL pulse one cycle with im_addr=word_cnt[ADDR_W-1:0] and the assembled word, and word_cnt SHALL increment.
REQ-011 After the N-th word write, DATA SHALL go to CKSUM if enabled, else ACK.
REQ-012 ACK SHALL wait for tx_busy=0, then pulse tx_start one cycle with tx_data=8'hAA and go to WAIT_TX.
REQ-013 WAIT_TX SHALL wait at least one cycle and until tx_busy=0, then go to DONE; done SHALL be 1 in DONE.
REQ-014 DONE and ERR SHALL be terminal until reset; start and bytes SHALL be ignored.
REQ-015 rx_ready with rx_ferr=1 in HDR, DATA or CKSUM SHALL go to ERR and discard the byte; no im_we for a partially assembled word.
REQ-016 Entering ERR SHALL send one byte 8'h55 using the ACK handshake rules, then assert err=1.
REQ-017 im_we SHALL never assert outside DATA; at most one write per 4 accepted bytes.
REQ-018 Byte-within-word counter (2 bits) SHALL wrap 3->0 on each completed word/header.

Reset
REQ-019 rstn=0 at a clock edge SHALL force IDLE, done=0, err=0, im_we=0, tx_start=0, tx_data=0, im_addr=0, im_wdata=0, word_cnt=0, header and byte counters 0, including mid-load.
REQ-020 A byte strobe coincident with reset SHALL be discarded.

Configuration
REQ-021 Macro PROG_LOADER_CHECKSUM_EN SHALL, when defined, enable CKSUM: one trailing byte equal to XOR of all data bytes (header excluded); match -> ACK, mismatch -> ERR.
REQ-022 Without PROG_LOADER_CHECKSUM_EN, CKSUM SHALL be unreachable and no trailing byte SHALL be expected.

Verification
REQ-023 start, bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> writes addr0=0x12345678, addr1=0x9ABCDEF0, tx 0xAA, done=1, word_cnt=2.
REQ-024 Header 00 00 00 00 -> no im_we, tx 0xAA, done=1.
REQ-025 ADDR_W=4, header 00 00 00 11 (17 words) -> ERR, tx 0x55, err=1, no writes.
REQ-026 Second data byte with rx_ferr=1 -> ERR, tx 0x55, no write for that word, err=1.
REQ-027 rstn=0 after 6 data bytes, then a full valid 1-word load -> only new word written at addr0, done=1.
REQ-028 With PROG_LOADER_CHECKSUM_EN, 1 word 01 02 04 08 then checksum 0x0F -> done; checksum 0x0E -> err=1, tx 0x55.
